// File: rtl/run_detect.sv
// Serial run detector: finds runs of RUN_LEN consecutive SYMBOL bits in a qualified
// bit stream and counts detections.
module run_detect #(
   parameter int unsigned RUN_LEN = 3,
   parameter logic        SYMBOL  = 1'b0,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned LW     = $clog2(RUN_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in,
   input  logic             mode,
   input  logic             clr_cnt,
   output logic             cb,
   output logic             is,
   output logic [LW-1:0]    run_len,
   output logic [CNT_W-1:0] det_cnt,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FULL,
      S_LONG
   } state_t;

   localparam logic [LW-1:0] RUN_LEN_W = LW'(RUN_LEN);

   state_t           state, state_n;
   logic [LW-1:0]    cnt, cnt_n;
   logic             mode_q, mode_eff;
   logic             is_n, cb_n, ovf_n;
   logic [CNT_W-1:0] det_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         mode_q  <= mode;
         cb      <= 1'b0;
         is      <= 1'b0;
         det_cnt <= '0;
         ovf     <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         mode_q  <= mode_eff;
         cb      <= cb_n;
         is      <= is_n;
         det_cnt <= det_n;
         ovf     <= ovf_n;
      end
   end

   // The mode input is only honoured in IDLE; mid-run the captured copy governs.
   always_comb begin
      mode_eff = (state == S_IDLE) ? mode : mode_q;
      state_n  = state;
      cnt_n    = cnt;
      is_n     = 1'b0;
      if (in_valid) begin
         if (in != SYMBOL) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            if (state == S_FULL && mode_eff)
               is_n = 1'b1;
         end else begin
            case (state)
               S_IDLE, S_RUN: begin
                  cnt_n = cnt + LW'(1);
                  if (cnt_n == RUN_LEN_W) begin
                     state_n = S_FULL;
                     is_n    = ~mode_eff;
                  end else begin
                     state_n = S_RUN;
                  end
               end
               S_FULL: begin
                  if (mode_eff) begin
                     state_n = S_LONG;
                     cnt_n   = RUN_LEN_W;
                  end else begin
                     state_n = S_RUN;
                     cnt_n   = LW'(1);
                  end
               end
               default: begin
                  state_n = S_LONG;
                  cnt_n   = RUN_LEN_W;
               end
            endcase
         end
      end
      cb_n = ((state_n == S_RUN) || (state_n == S_FULL && mode_eff)) && !is_n;
   end

   // A clear coincident with a detection leaves that detection counted.
   always_comb begin
      det_n = det_cnt;
      ovf_n = ovf;
      if (clr_cnt) begin
         det_n = is_n ? CNT_W'(1) : '0;
         ovf_n = 1'b0;
      end else if (is_n) begin
         if (&det_cnt)
            ovf_n = 1'b1;
         else
            det_n = det_cnt + CNT_W'(1);
      end
   end

   assign run_len = cnt;

endmodule

// File: tb/tb_run_detect.sv
// Directed self-checking bench for run_detect (default instance plus a CNT_W=2 instance).
module tb_run_detect;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b1;
   logic       mode = 1'b0;
   logic       clr_cnt = 1'b0;

   logic       cb, is, ovf;
   logic [1:0] run_len;
   logic [7:0] det_cnt;
   logic       cb2, is2, ovf2;
   logic [1:0] run_len2;
   logic [1:0] det_cnt2;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   run_detect dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .mode(mode),
      .clr_cnt(clr_cnt), .cb(cb), .is(is), .run_len(run_len),
      .det_cnt(det_cnt), .ovf(ovf)
   );

   run_detect #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .mode(mode),
      .clr_cnt(clr_cnt), .cb(cb2), .is(is2), .run_len(run_len2),
      .det_cnt(det_cnt2), .ovf(ovf2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic m);
      rst  = 1'b0;
      mode = m;
      step(1'b0, 1'b1);
      rst  = 1'b1;
   endtask

   initial begin
      logic [1:0] e_len [6];
      logic       e_is  [6];
      logic       e_cb  [6];

      // reset state
      do_reset(1'b0);
      check("rst_cb", cb, 0);
      check("rst_is", is, 0);
      check("rst_len", run_len, 0);
      check("rst_det", det_cnt, 0);
      check("rst_ovf", ovf, 0);

      // chunk mode, six symbols
      e_len = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
      e_is  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      e_cb  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0);
         check("chunk_len", run_len, e_len[i]);
         check("chunk_is", is, e_is[i]);
         check("chunk_cb", cb, e_cb[i]);
      end
      check("chunk_det", det_cnt, 2);

      // exact mode, run terminated by a 1
      do_reset(1'b1);
      e_cb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      e_is = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, (i == 3) ? 1'b1 : 1'b0);
         check("exact_cb", cb, e_cb[i]);
         check("exact_is", is, e_is[i]);
      end
      check("exact_det", det_cnt, 1);

      // exact mode, over-long run never detects
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         check("long_is", is, 0);
      end
      check("long_len", run_len, 3);
      check("long_cb", cb, 0);
      step(1'b1, 1'b1);
      check("long_end_is", is, 0);
      check("long_end_len", run_len, 0);
      check("long_det", det_cnt, 1);

      // in_valid gaps hold the partial run
      do_reset(1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1);
         check("gap_len", run_len, 2);
         check("gap_is", is, 0);
      end
      step(1'b1, 1'b0);
      check("gap_done_is", is, 1);
      check("gap_done_len", run_len, 3);

      // reset mid-run discards it
      do_reset(1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      rst = 1'b0;
      step(1'b1, 1'b0);
      rst = 1'b1;
      check("midrst_len", run_len, 0);
      step(1'b1, 1'b0);
      check("midrst_len2", run_len, 1);
      check("midrst_is", is, 0);
      check("midrst_det", det_cnt, 0);

      // CNT_W=2 saturation, overflow, coincident clear
      do_reset(1'b0);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
         check("sat_is", is2, 1);
         check("sat_det", det_cnt2, (r == 3) ? 3 : r + 1);
         check("sat_ovf", ovf2, (r == 3) ? 1 : 0);
      end
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      clr_cnt = 1'b1;
      step(1'b1, 1'b0);
      check("clr_is", is2, 1);
      check("clr_det", det_cnt2, 1);
      check("clr_ovf", ovf2, 0);
      check("clr_len", run_len2, 3);
      step(1'b0, 1'b1);
      clr_cnt = 1'b0;
      check("clr_only_det", det_cnt2, 0);

      // mode change mid-run applies from next IDLE
      do_reset(1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      mode = 1'b1;
      step(1'b1, 1'b0);
      check("modesw_is", is, 1);
      check("modesw_cb", cb, 0);
      step(1'b1, 1'b1);
      check("modesw_idle_is", is, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      check("modesw_ex_is", is, 0);
      check("modesw_ex_cb", cb, 1);
      step(1'b1, 1'b1);
      check("modesw_ex_end", is, 1);
      check("modesw_det", det_cnt, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
